// File: rtl/als_pkg.sv
`default_nettype none
// =============================================================================
// als_pkg: shared FSM state, default frame geometry and frame builder for the
//          Pmod ALS responder.  Revision: 1.0
// =============================================================================
package als_pkg;

  localparam int LEAD_ZEROS_DEF = 3;
  localparam int DATA_BITS_DEF  = 8;
  localparam int FRAME_BITS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
  } state_e;

  // Returns {lead zeros, sample, trailing zeros} right-aligned in 64 bits;
  // callers keep the low 'frame' bits.
  function automatic logic [63:0] build_frame(input logic [63:0] sample,
                                              input int lead,
                                              input int data,
                                              input int frame);
    logic [63:0] mask;
    mask = (data >= 64) ? '1 : ((64'd1 << data) - 64'd1);
    return (sample & mask) << (frame - lead - data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// =============================================================================
// spi_sync_edge: multi-flop synchronizer with registered-copy rise/fall pulses.
//                Revision: 1.0
// =============================================================================
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/als_spi_responder.sv
`default_nettype none
// =============================================================================
// als_spi_responder: SPI target serving ADC081S021-style frames (Pmod ALS).
// Option macro ALS_RESP_FRAME_CHECK_EN: classify frames by sclk rise count.
// Revision: 1.0
// =============================================================================
module als_spi_responder
  import als_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 sclk,
  input  logic [DATA_BITS-1:0] i_Sample,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 o_Busy,
  output logic                 o_Frame_Done,
  output logic                 o_Frame_Err
);

  localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] FALL_MAX = CNT_W'(FRAME_BITS);

  logic w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall;

  // cs resets to "low seen" so a cs already low at reset release is not a fall.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (cs),
    .rise_o (w_cs_rise),
    .fall_o (w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (sclk),
    .rise_o (w_sclk_rise),
    .fall_o (w_sclk_fall)
  );

  logic [FRAME_BITS-1:0] w_frame;
  assign w_frame = FRAME_BITS'(build_frame(64'(i_Sample), LEAD_ZEROS, DATA_BITS, FRAME_BITS));

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      fall_cnt_q, fall_cnt_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  w_frame_ok;

`ifdef ALS_RESP_FRAME_CHECK_EN
  // Saturating one past FRAME_BITS keeps over-clocked frames distinguishable.
  localparam logic [CNT_W-1:0] RISE_MAX = CNT_W'(FRAME_BITS + 1);
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic             err_q, err_d;
  assign w_frame_ok  = (rise_cnt_q == FALL_MAX);
  assign o_Frame_Err = err_q;
`else
  logic w_unused_sclk_rise;
  assign w_unused_sclk_rise = w_sclk_rise;
  assign w_frame_ok  = 1'b1;
  assign o_Frame_Err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      fall_cnt_q <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ALS_RESP_FRAME_CHECK_EN
      rise_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      fall_cnt_q <= fall_cnt_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ALS_RESP_FRAME_CHECK_EN
      rise_cnt_q <= rise_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    fall_cnt_d = fall_cnt_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef ALS_RESP_FRAME_CHECK_EN
    rise_cnt_d = rise_cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_cs_fall) begin
          state_d    = ST_SHIFT;
          shreg_d    = w_frame;
          miso_d     = w_frame[FRAME_BITS-1];
          oe_d       = 1'b1;
          busy_d     = 1'b1;
          fall_cnt_d = '0;
`ifdef ALS_RESP_FRAME_CHECK_EN
          rise_cnt_d = '0;
`endif
        end
      end
      ST_SHIFT: begin
        // A cs rise masks any sclk edge seen in the same clk.
        if (w_cs_rise) begin
          state_d = ST_END;
          shreg_d = '0;
          miso_d  = 1'b0;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = w_frame_ok;
`ifdef ALS_RESP_FRAME_CHECK_EN
          err_d   = !w_frame_ok;
`endif
        end else begin
          if (w_sclk_fall) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
            miso_d  = shreg_q[FRAME_BITS-2];
            if (fall_cnt_q != FALL_MAX) fall_cnt_d = fall_cnt_q + CNT_W'(1);
          end
`ifdef ALS_RESP_FRAME_CHECK_EN
          if (w_sclk_rise && (rise_cnt_q != RISE_MAX)) rise_cnt_d = rise_cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign miso         = miso_q;
  assign miso_oe      = oe_q;
  assign o_Busy       = busy_q;
  assign o_Frame_Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_als_spi_responder.sv
`default_nettype none
// =============================================================================
// tb_als_spi_responder: directed plus randomized frames against a frame model.
// Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_als_spi_responder;

  localparam int SYNC  = 2;
  localparam int LEAD  = 3;
  localparam int DATA  = 8;
  localparam int FRAME = 16;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic       sclk = 1'b1;
  logic [7:0] i_Sample = 8'h00;
  logic       miso, miso_oe, o_Busy, o_Frame_Done, o_Frame_Err;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int err_seen    = 0;

  always #5 clk = ~clk;

  als_spi_responder #(
    .SYNC_STAGES (SYNC),
    .LEAD_ZEROS  (LEAD),
    .DATA_BITS   (DATA),
    .FRAME_BITS  (FRAME)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .sclk         (sclk),
    .i_Sample     (i_Sample),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .o_Busy       (o_Busy),
    .o_Frame_Done (o_Frame_Done),
    .o_Frame_Err  (o_Frame_Err)
  );

  always @(negedge clk) begin
    if (o_Frame_Done) done_seen++;
    if (o_Frame_Err)  err_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the master sees the frame MSB first, then zeros once exhausted.
  function automatic logic [31:0] model_frame(input logic [7:0] s);
    return 32'(s) << (FRAME - LEAD - DATA);
  endfunction

  function automatic logic [31:0] model_capture(input logic [7:0] s, input int n);
    logic [31:0] f;
    logic [31:0] w;
    f = model_frame(s);
    w = '0;
    for (int i = 0; i < n; i++) w = {w[30:0], (i < FRAME) ? f[FRAME-1-i] : 1'b0};
    return w;
  endfunction

  function automatic bit model_ok(input int n);
`ifdef ALS_RESP_FRAME_CHECK_EN
    return (n == FRAME);
`else
    return 1'b1;
`endif
  endfunction

  // Enter and leave at a negedge with cs high.  gap = clk cycles cs stays high.
  task automatic run_frame(input logic [7:0] samp, input int n, input int chg_at,
                           input logic [7:0] chg_val, input int gap, input string tag);
    int          d0, e0;
    logic [31:0] cap;
    bit          ok;
    d0 = done_seen;
    e0 = err_seen;
    cap = '0;
    i_Sample = samp;
    cs = 1'b0;
    repeat (SYNC) @(negedge clk);
    chk({tag, ".oe_pre"}, 32'(miso_oe), 32'd0);
    @(negedge clk);
    chk({tag, ".oe_on"}, {30'd0, miso_oe, o_Busy}, 32'd3);
    repeat (HALF - SYNC - 1) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      cap = {cap[30:0], miso};
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      if (i + 1 == chg_at) i_Sample = chg_val;
      repeat (HALF) @(negedge clk);
    end
    chk({tag, ".data"}, cap, model_capture(samp, n));
    ok = model_ok(n);
    cs = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk({tag, ".pre_status"}, {30'd0, o_Frame_Done, o_Frame_Err}, 32'd0);
    @(negedge clk);
    chk({tag, ".status"}, {27'd0, o_Frame_Done, o_Frame_Err, miso_oe, miso, o_Busy},
        {27'd0, ok, !ok, 3'b000});
    @(negedge clk);
    chk({tag, ".pulse"}, (done_seen - d0) * 16 + (err_seen - e0), ok ? 32'd16 : 32'd1);
    repeat (gap - (SYNC + 2)) @(negedge clk);
  endtask

  initial begin
    int d0, e0;
    logic [7:0] s, cv;
    int n, ca, g;

    repeat (4) @(negedge clk);
    chk("reset", {27'd0, miso, miso_oe, o_Busy, o_Frame_Done, o_Frame_Err}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    run_frame(8'hA5, 16, -1, 8'h00, 8, "a5");
    chk("a5_word", model_capture(8'hA5, 16), 32'h14A0);
    run_frame(8'hFF, 16, 5, 8'h00, 8, "ff_chg");
    run_frame(8'h5A, 10, -1, 8'h00, 8, "short10");
    run_frame(8'h3C, 16, -1, 8'h00, 8, "3c");
    run_frame(8'h96, 20, -1, 8'h00, 8, "long20");

    // Reset in the middle of a frame, released with cs still low.
    d0 = done_seen;
    e0 = err_seen;
    i_Sample = 8'hC3;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    chk("mid_busy", {30'd0, miso_oe, o_Busy}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {27'd0, miso, miso_oe, o_Busy, o_Frame_Done, o_Frame_Err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("cs_low_at_release", {30'd0, miso_oe, o_Busy}, 32'd0);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_no_pulse", (done_seen - d0) * 16 + (err_seen - e0), 32'd0);
    run_frame(8'h01, 16, -1, 8'h00, 8, "after_rst");

    run_frame(8'h12, 16, -1, 8'h00, SYNC + 2, "b2b_12");
    run_frame(8'h34, 16, -1, 8'h00, 8, "b2b_34");

    for (int k = 0; k < 16; k++) begin
      s  = 8'($urandom);
      cv = 8'($urandom);
      n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : FRAME;
      ca = int'($urandom_range(1, 15));
      g  = int'($urandom_range(SYNC + 2, 12));
      run_frame(s, n, ca, cv, g, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
